nanci_row_drain: RTL

// - Output stage downstream of the PE mesh: after a sort pass, snapshots the o_PE words of one mesh row
//   and serialises them, leftmost PE first, onto a valid/ready stream for the host/collector.
// - One instance per row; the mesh controller pulses i_start when the row's sort/compute cycles end.

---
 rtl/nanci_pkg.sv | 14 +
 rtl/nanci_row_drain.sv | 87 ++++++++
 2 files changed

// File: rtl/nanci_pkg.sv
// nanci_pkg: shared word-width constants, field helpers and drain state enum for the row drain
package nanci_pkg;
  localparam int NANCI_ADDR_W = 3;
  localparam int NANCI_DATA_W = 3;
  localparam int NANCI_SQRT_N = 4;
  localparam int W = NANCI_ADDR_W + NANCI_DATA_W;
  typedef enum logic [1:0] {IDLE, DRAIN, DONE} drain_state_e;
  function automatic logic [NANCI_ADDR_W-1:0] addr_of(input logic [W-1:0] w);
    return w[W-1:NANCI_DATA_W];
  endfunction
  function automatic logic [NANCI_DATA_W-1:0] data_of(input logic [W-1:0] w);
    return w[NANCI_DATA_W-1:0];
  endfunction
endpackage

// File: rtl/nanci_row_drain.sv
// nanci_row_drain: snapshots one mesh row of PE words and streams them leftmost first (optional NANCI_DRAIN_ORDER_CHECK_EN)
module nanci_row_drain
  import nanci_pkg::*;
#(
  parameter int ADDR_WIDTH = NANCI_ADDR_W,
  parameter int DATA_WIDTH = NANCI_DATA_W,
  parameter int SQRT_N     = NANCI_SQRT_N
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       i_start,
  input  logic [SQRT_N*(ADDR_WIDTH+DATA_WIDTH)-1:0]  i_row,
  output logic                                       o_valid,
  input  logic                                       i_ready,
  output logic [ADDR_WIDTH+DATA_WIDTH-1:0]           o_word,
  output logic                                       o_last,
  output logic                                       o_busy,
  output logic                                       o_done,
  output logic                                       o_err
);
  localparam int WORD_W = ADDR_WIDTH + DATA_WIDTH;
  localparam int IW = SQRT_N > 1 ? $clog2(SQRT_N) : 1;
  localparam logic [IW-1:0] LAST = IW'(SQRT_N - 1);
  drain_state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [SQRT_N*WORD_W-1:0] snap_q, snap_d;
  logic [WORD_W-1:0] word;
  logic hs;
  assign word = snap_q[idx_q*WORD_W +: WORD_W];
  // state, index and snapshot registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
    end
  end
  // capture on start in IDLE, advance on handshake, one-cycle DONE pulse
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    snap_d  = snap_q;
    o_valid = state_q == DRAIN;
    o_last  = o_valid && idx_q == LAST;
    o_word  = o_valid ? word : '0;
    o_busy  = o_valid;
    o_done  = state_q == DONE;
    hs      = o_valid && i_ready;
    case (state_q)
      IDLE: if (i_start) begin
        snap_d  = i_row;
        idx_d   = '0;
        state_d = DRAIN;
      end
      DRAIN: if (hs) begin
        state_d = o_last ? DONE : DRAIN;
        idx_d   = o_last ? idx_q : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
`ifdef NANCI_DRAIN_ORDER_CHECK_EN
  logic err_q, err_d;
  logic [DATA_WIDTH-1:0] prev_q, prev_d;
  logic [DATA_WIDTH-1:0] data;
  assign data  = word[DATA_WIDTH-1:0];
  assign err_d = err_q | (hs && idx_q != '0 && data < prev_q);
  assign prev_d = hs ? data : prev_q;
  assign o_err = err_q;
  // sticky descending-data flag against the previous accepted word of this drain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q  <= 1'b0;
      prev_q <= '0;
    end else begin
      err_q  <= err_d;
      prev_q <= prev_d;
    end
  end
`else
  assign o_err = 1'b0;
`endif
endmodule
